// File: rtl/drv_dac_spi_multi.sv
// SPI DAC sweep driver: snapshots up to 16 channels and sends addressed 16-bit frames (SYNC/SCLK/DIN); DAC_LDAC_EN adds an LDAC strobe.
// Latency: start seen in cycle t -> SNAP t+1, LOAD t+2, SYNC low t+3; a frame occupies 1 + 32*CLK_DIV + GAP_CYC cycles.
// Backpressure: none; triggers are ignored while busy, including the sweep_done cycle.
module drv_dac_spi_multi #(
    parameter int NUM_CH  = 8,
    parameter int DATA_W  = 12,
    parameter int CLK_DIV = 5,
    parameter int GAP_CYC = 100
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     mode,
    input  logic                     trigger,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [NUM_CH*DATA_W-1:0] dac_data,
    output logic                     busy,
    output logic                     sweep_done,
    output logic                     SYNC,
    output logic                     SCLK,
    output logic                     DIN
`ifdef DAC_LDAC_EN
    ,
    output logic                     LDAC
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_SNAP, S_LOAD, S_SHIFT, S_GAP, S_LDAC, S_DONE
    } state_t;

    state_t                   state;
    logic [NUM_CH*DATA_W-1:0] data_snap;
    logic [NUM_CH-1:0]        mask_snap;
    logic [3:0]               ptr;
    logic [3:0]               bit_cnt;
    logic [15:0]              cnt;
    logic [15:0]              sreg;

    logic [3:0]               first_ch;
    logic                     first_ok;
    logic [3:0]               next_ch;
    logic                     next_ok;
    logic [DATA_W-1:0]        cur_data;
    logic [11:0]              code;
    logic [15:0]              frame;
    logic                     start;

    assign start = enable && (|ch_mask) && (!mode || trigger);

    // Descending scan so the lowest qualifying index wins.
    always_comb begin
        first_ch = '0;
        first_ok = 1'b0;
        next_ch  = '0;
        next_ok  = 1'b0;
        cur_data = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                first_ch = 4'(i);
                first_ok = 1'b1;
            end
            if (mask_snap[i] && (4'(i) > ptr)) begin
                next_ch = 4'(i);
                next_ok = 1'b1;
            end
            if (ptr == 4'(i)) begin
                cur_data = data_snap[i*DATA_W +: DATA_W];
            end
        end
    end

    assign code  = 12'(cur_data) << (12 - DATA_W);
    assign frame = {ptr, code};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
            SYNC       <= 1'b1;
            SCLK       <= 1'b1;
            DIN        <= 1'b0;
            data_snap  <= '0;
            mask_snap  <= '0;
            ptr        <= '0;
            bit_cnt    <= '0;
            cnt        <= '0;
            sreg       <= '0;
`ifdef DAC_LDAC_EN
            LDAC       <= 1'b1;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    SYNC <= 1'b1;
                    SCLK <= 1'b1;
                    DIN  <= 1'b0;
                    if (start) begin
                        state <= S_SNAP;
                        busy  <= 1'b1;
                    end
                end
                S_SNAP: begin
                    data_snap <= dac_data;
                    mask_snap <= ch_mask;
                    ptr       <= first_ch;
                    if (first_ok) begin
                        state <= S_LOAD;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    SYNC    <= 1'b0;
                    SCLK    <= 1'b1;
                    DIN     <= frame[15];
                    sreg    <= {frame[14:0], 1'b0};
                    cnt     <= '0;
                    bit_cnt <= '0;
                    state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    // SCLK doubles as the half-period phase; DIN only moves on the rising half.
                    if (cnt == 16'(CLK_DIV - 1)) begin
                        cnt <= '0;
                        if (SCLK) begin
                            SCLK <= 1'b0;
                        end else if (bit_cnt == 4'd15) begin
                            SYNC  <= 1'b1;
                            SCLK  <= 1'b1;
                            DIN   <= 1'b0;
                            state <= S_GAP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            SCLK    <= 1'b1;
                            DIN     <= sreg[15];
                            sreg    <= {sreg[14:0], 1'b0};
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (cnt == 16'(GAP_CYC - 1)) begin
                        cnt <= '0;
                        if (!enable) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else if (next_ok) begin
                            ptr   <= next_ch;
                            state <= S_LOAD;
                        end else begin
`ifdef DAC_LDAC_EN
                            LDAC  <= 1'b0;
                            state <= S_LDAC;
`else
                            sweep_done <= 1'b1;
                            state      <= S_DONE;
`endif
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
`ifdef DAC_LDAC_EN
                S_LDAC: begin
                    if (cnt == 16'(2*CLK_DIV - 1)) begin
                        cnt        <= '0;
                        LDAC       <= 1'b1;
                        sweep_done <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
`endif
                S_DONE: begin
                    sweep_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drv_dac_spi_multi.sv
// Directed bench for drv_dac_spi_multi; a pin monitor rebuilds frames from SYNC/SCLK/DIN.
module tb_drv_dac_spi_multi;

    localparam int NUM_CH    = 8;
    localparam int DATA_W    = 12;
    localparam int CLK_DIV   = 5;
    localparam int GAP_CYC   = 100;
    localparam int SHIFT_CYC = 32 * CLK_DIV;
`ifdef DAC_LDAC_EN
    localparam int LDAC_CYC  = 2 * CLK_DIV;
`else
    localparam int LDAC_CYC  = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic enable = 1'b0;
    logic mode = 1'b0;
    logic trigger = 1'b0;
    logic [NUM_CH-1:0] ch_mask = '0;
    logic [NUM_CH*DATA_W-1:0] dac_data = '0;
    logic busy, sweep_done, SYNC, SCLK, DIN;
`ifdef DAC_LDAC_EN
    logic LDAC;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    drv_dac_spi_multi #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .trigger(trigger),
        .ch_mask(ch_mask), .dac_data(dac_data), .busy(busy), .sweep_done(sweep_done),
        .SYNC(SYNC), .SCLK(SCLK), .DIN(DIN)
`ifdef DAC_LDAC_EN
        , .LDAC(LDAC)
`endif
    );

    always #5 clk = ~clk;

    // Pin monitor
    int cyc = 0;
    logic sync_q = 1'b1, sclk_q = 1'b1, din_q = 1'b0;
    logic [15:0] fr_word = '0;
    int fr_bits = 0, fr_len = 0, last_fall = 0;
    int per_bad = 0, din_bad = 0, done_cnt = 0;
    logic [15:0] frame_q[$];
    int bits_q[$];
    int len_q[$];
    int fall_q[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (sync_q && !SYNC) begin
            fr_word = '0;
            fr_bits = 0;
            fr_len  = 0;
            fall_q.push_back(cyc);
        end
        if (SYNC === 1'b0) begin
            fr_len++;
            if (sclk_q && !SCLK) begin
                if (fr_bits > 0 && (cyc - last_fall) != 2*CLK_DIV) per_bad++;
                last_fall = cyc;
                fr_word = {fr_word[14:0], DIN};
                fr_bits++;
            end
            if (DIN !== din_q && !SCLK) din_bad++;
        end
        if (!sync_q && SYNC) begin
            frame_q.push_back(fr_word);
            bits_q.push_back(fr_bits);
            len_q.push_back(fr_len);
        end
        if (sweep_done === 1'b1) done_cnt++;
        sync_q = SYNC;
        sclk_q = SCLK;
        din_q  = DIN;
    end

    task automatic clear_mon();
        frame_q.delete();
        bits_q.delete();
        len_q.delete();
        fall_q.delete();
        per_bad  = 0;
        din_bad  = 0;
        done_cnt = 0;
    endtask

    function automatic logic [15:0] fq(input int i);
        if (i < frame_q.size()) return frame_q[i];
        return 16'hxxxx;
    endfunction

    function automatic int fb(input int i);
        if (i < bits_q.size()) return bits_q[i];
        return -1;
    endfunction

    function automatic int fl(input int i);
        if (i < len_q.size()) return len_q[i];
        return -1;
    endfunction

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ch(input int ch, input logic [DATA_W-1:0] v);
        dac_data[ch*DATA_W +: DATA_W] = v;
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
    endtask

    task automatic wait_fall(output bit ok);
        logic prev;
        prev = SYNC;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            if (prev && !SYNC) begin
                ok = 1'b1;
                break;
            end
            prev = SYNC;
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk);
            #1;
            if (sweep_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_cmp++; if (SYNC !== 1'b1) begin n_fail++; $display("FAIL reset_sync: got %b want 1", SYNC); end
        n_cmp++; if (SCLK !== 1'b1) begin n_fail++; $display("FAIL reset_sclk: got %b want 1", SCLK); end
        n_cmp++; if (DIN !== 1'b0) begin n_fail++; $display("FAIL reset_din: got %b want 0", DIN); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (sweep_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", sweep_done); end
`ifdef DAC_LDAC_EN
        n_cmp++; if (LDAC !== 1'b1) begin n_fail++; $display("FAIL reset_ldac: got %b want 1", LDAC); end
`endif
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        clear_mon();
        // Continuous mode with an empty mask must stay idle.
        mode = 1'b0;
        ch_mask = '0;
        enable = 1'b1;
        tick(30);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mask0_busy: got %b want 0", busy); end
        n_cmp++; if (fall_q.size() != 0) begin n_fail++; $display("FAIL mask0_frames: got %0d want 0", fall_q.size()); end
        n_cmp++; if (done_cnt != 0) begin n_fail++; $display("FAIL mask0_done: got %0d want 0", done_cnt); end
    endtask

    task automatic test_single();
        int n;
        mode = 1'b1;
        ch_mask = 8'h01;
        set_ch(0, 12'hABC);
        clear_mon();
        pulse_trigger();
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_snap: got %b want 1", busy); end
        tick(1);
        n_cmp++; if (SYNC !== 1'b1) begin n_fail++; $display("FAIL single_sync_load: got %b want 1", SYNC); end
        tick(1);
        n_cmp++; if (SYNC !== 1'b0) begin n_fail++; $display("FAIL single_sync_fall: got %b want 0", SYNC); end
        n = 0;
        while (!sweep_done && n < 2000) begin
            tick(1);
            n++;
        end
        n_cmp++; if (n != SHIFT_CYC + GAP_CYC + LDAC_CYC) begin n_fail++; $display("FAIL single_done_time: got %0d want %0d", n, SHIFT_CYC + GAP_CYC + LDAC_CYC); end
        tick(1);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy); end
        n_cmp++; if (sweep_done !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %b want 0", sweep_done); end
        n_cmp++; if (fq(0) !== 16'h0ABC) begin n_fail++; $display("FAIL single_word: got %h want 0abc", fq(0)); end
        n_cmp++; if (fb(0) != 16) begin n_fail++; $display("FAIL single_bits: got %0d want 16", fb(0)); end
        n_cmp++; if (fl(0) != SHIFT_CYC) begin n_fail++; $display("FAIL single_sync_len: got %0d want %0d", fl(0), SHIFT_CYC); end
        n_cmp++; if (per_bad != 0) begin n_fail++; $display("FAIL single_sclk_period: got %0d bad want 0", per_bad); end
        n_cmp++; if (din_bad != 0) begin n_fail++; $display("FAIL single_din_stable: got %0d bad want 0", din_bad); end
        n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
        tick(300);
        n_cmp++; if (fall_q.size() != 1) begin n_fail++; $display("FAIL single_no_repeat: got %0d want 1", fall_q.size()); end
    endtask

    task automatic test_continuous();
        int addr[4] = '{0, 2, 5, 7};
        int seen;
        logic [15:0] exp_w;
        int exp_gap;
        enable = 1'b0;
        tick(2);
        mode = 1'b0;
        ch_mask = 8'hA5;
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 12'(12'h5A0 + i));
        clear_mon();
        enable = 1'b1;
        seen = 0;
        for (int k = 0; k < 3000 && seen < 2; k++) begin
            tick(1);
            if (sweep_done) seen++;
        end
        enable = 1'b0;
        n_cmp++; if (seen != 2) begin n_fail++; $display("FAIL cont_sweeps: got %0d want 2", seen); end
        tick(20);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_busy_end: got %b want 0", busy); end
        n_cmp++; if (fall_q.size() != 8) begin n_fail++; $display("FAIL cont_frames: got %0d want 8", fall_q.size()); end
        for (int i = 0; i < 8; i++) begin
            exp_w = {4'(addr[i % 4]), 12'(12'h5A0 + addr[i % 4])};
            n_cmp++; if (fq(i) !== exp_w) begin n_fail++; $display("FAIL cont_word%0d: got %h want %h", i, fq(i), exp_w); end
        end
        for (int i = 1; i < 8 && i < fall_q.size(); i++) begin
            exp_gap = (i == 4) ? (SHIFT_CYC + GAP_CYC + 4 + LDAC_CYC) : (SHIFT_CYC + GAP_CYC + 1);
            n_cmp++; if (fall_q[i] - fall_q[i-1] != exp_gap) begin n_fail++; $display("FAIL cont_spacing%0d: got %0d want %0d", i, fall_q[i] - fall_q[i-1], exp_gap); end
        end
        n_cmp++; if (per_bad != 0 || din_bad != 0) begin n_fail++; $display("FAIL cont_pins: got per %0d din %0d want 0 0", per_bad, din_bad); end
    endtask

    task automatic test_snapshot();
        bit ok;
        enable = 1'b0;
        tick(2);
        mode = 1'b1;
        ch_mask = 8'h21;
        set_ch(0, 12'h007);
        set_ch(5, 12'h111);
        clear_mon();
        enable = 1'b1;
        pulse_trigger();
        wait_fall(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL snap_fall_timeout: got none want fall"); end
        set_ch(5, 12'h222);
        ch_mask = 8'h01;
        pulse_trigger();
        wait_done(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL snap_done_timeout: got none want pulse"); end
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL snap_busy_end: got %b want 0", busy); end
        tick(30);
        n_cmp++; if (fall_q.size() != 2) begin n_fail++; $display("FAIL snap_frames: got %0d want 2", fall_q.size()); end
        n_cmp++; if (fq(0) !== 16'h0007) begin n_fail++; $display("FAIL snap_word0: got %h want 0007", fq(0)); end
        n_cmp++; if (fq(1) !== 16'h5111) begin n_fail++; $display("FAIL snap_word1: got %h want 5111", fq(1)); end
        ch_mask = 8'h21;
        pulse_trigger();
        wait_done(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL snap_done2_timeout: got none want pulse"); end
        tick(2);
        n_cmp++; if (fq(3) !== 16'h5222) begin n_fail++; $display("FAIL snap_word_next: got %h want 5222", fq(3)); end
    endtask

    task automatic test_enable_drop();
        bit ok;
        enable = 1'b0;
        tick(2);
        mode = 1'b1;
        ch_mask = 8'hFF;
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 12'(12'h800 + i));
        clear_mon();
        enable = 1'b1;
        pulse_trigger();
        for (int f = 0; f < 4; f++) begin
            wait_fall(ok);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL drop_fall%0d_timeout: got none want fall", f); end
        end
        tick(50);
        enable = 1'b0;
        tick(209);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drop_busy_gap: got %b want 1", busy); end
        n_cmp++; if (SYNC !== 1'b1) begin n_fail++; $display("FAIL drop_sync_gap: got %b want 1", SYNC); end
        tick(1);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy_idle: got %b want 0", busy); end
        tick(300);
        n_cmp++; if (fall_q.size() != 4) begin n_fail++; $display("FAIL drop_frames: got %0d want 4", fall_q.size()); end
        n_cmp++; if (fq(3) !== 16'h3803) begin n_fail++; $display("FAIL drop_word3: got %h want 3803", fq(3)); end
        n_cmp++; if (fb(3) != 16) begin n_fail++; $display("FAIL drop_bits3: got %0d want 16", fb(3)); end
        n_cmp++; if (done_cnt != 0) begin n_fail++; $display("FAIL drop_done: got %0d want 0", done_cnt); end
`ifdef DAC_LDAC_EN
        n_cmp++; if (LDAC !== 1'b1) begin n_fail++; $display("FAIL drop_ldac: got %b want 1", LDAC); end
`endif
    endtask

    task automatic test_reset_mid();
        bit ok;
        enable = 1'b1;
        mode = 1'b1;
        ch_mask = 8'h01;
        set_ch(0, 12'hFFF);
        clear_mon();
        pulse_trigger();
        wait_fall(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rstmid_fall_timeout: got none want fall"); end
        tick(45);
        n_cmp++; if ({SYNC, SCLK, DIN} !== 3'b001) begin n_fail++; $display("FAIL rstmid_pre: got %b want 001", {SYNC, SCLK, DIN}); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({SYNC, SCLK, DIN, busy} !== 4'b1100) begin n_fail++; $display("FAIL rstmid_async: got %b want 1100", {SYNC, SCLK, DIN, busy}); end
        tick(3);
        rst_n = 1'b1;
        clear_mon();
        tick(300);
        n_cmp++; if (fall_q.size() != 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d want 0", fall_q.size()); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        pulse_trigger();
        wait_done(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rstmid_done_timeout: got none want pulse"); end
        n_cmp++; if (fq(0) !== 16'h0FFF || fb(0) != 16) begin n_fail++; $display("FAIL rstmid_word: got %h/%0d want 0fff/16", fq(0), fb(0)); end
    endtask

`ifdef DAC_LDAC_EN
    task automatic test_ldac();
        bit ok;
        enable = 1'b1;
        mode = 1'b1;
        ch_mask = 8'h03;
        set_ch(0, 12'h123);
        set_ch(1, 12'h456);
        clear_mon();
        pulse_trigger();
        for (int f = 0; f < 2; f++) begin
            wait_fall(ok);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL ldac_fall%0d_timeout: got none want fall", f); end
        end
        tick(259);
        n_cmp++; if (LDAC !== 1'b1) begin n_fail++; $display("FAIL ldac_pre: got %b want 1", LDAC); end
        tick(1);
        n_cmp++; if ({LDAC, busy, SYNC} !== 3'b011) begin n_fail++; $display("FAIL ldac_low: got %b want 011", {LDAC, busy, SYNC}); end
        tick(9);
        n_cmp++; if ({LDAC, sweep_done} !== 2'b00) begin n_fail++; $display("FAIL ldac_hold: got %b want 00", {LDAC, sweep_done}); end
        tick(1);
        n_cmp++; if ({LDAC, sweep_done, busy} !== 3'b111) begin n_fail++; $display("FAIL ldac_rise: got %b want 111", {LDAC, sweep_done, busy}); end
        tick(1);
        n_cmp++; if ({busy, sweep_done} !== 2'b00) begin n_fail++; $display("FAIL ldac_end: got %b want 00", {busy, sweep_done}); end
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_single();
        test_continuous();
        test_snapshot();
        test_enable_drop();
        test_reset_mid();
`ifdef DAC_LDAC_EN
        test_ldac();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
